// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide scalar types.
package cpu_types_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/dcache_pkg.sv
// Data cache types: FSM states, frame layout and address-split helpers.
package dcache_pkg;
  import cpu_types_pkg::*;

  localparam int BLK_OFF_BIT = 2;
  localparam int IDX_LSB     = 3;
  // Widest tag occurs at the smallest legal index width (1 bit).
  localparam int TAG_MAX_W   = WORD_W - IDX_LSB - 1;

  typedef logic [TAG_MAX_W-1:0] tag_t;

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, LD0, LD1, FCHK, FWB0, FWB1, HALTED
  } dcache_state_t;

  typedef struct packed {
    logic        valid;
    logic        dirty;
    tag_t        tag;
    word_t [1:0] word;
  } dcache_frame_t;

  function automatic tag_t addr_tag(input word_t addr, input int idx_w);
    return tag_t'(addr >> (IDX_LSB + idx_w));
  endfunction

  function automatic word_t block_addr(input tag_t tag, input word_t idx,
                                       input int idx_w, input logic off);
    return (word_t'(tag) << (IDX_LSB + idx_w)) | (idx << IDX_LSB) |
           (word_t'(off) << BLK_OFF_BIT);
  endfunction
endpackage

// File: rtl/dcache_frames.sv
// Direct-mapped frame array: combinational read port, one registered write port.
module dcache_frames
  import cpu_types_pkg::*;
  import dcache_pkg::*;
#(
  parameter int SETS = 8,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [IDX_W-1:0] rd_idx,
  output dcache_frame_t    rd_frame,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  dcache_frame_t    wr_frame
);
  logic [SETS-1:0] valid_q, valid_d;
  logic [SETS-1:0] dirty_q, dirty_d;
  tag_t            tag_mem  [SETS];
  word_t [1:0]     word_mem [SETS];

  always_comb begin
    rd_frame.valid = valid_q[rd_idx];
    rd_frame.dirty = dirty_q[rd_idx];
    rd_frame.tag   = tag_mem[rd_idx];
    rd_frame.word  = word_mem[rd_idx];
  end

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_en) begin
      valid_d[wr_idx] = wr_frame.valid;
      dirty_d[wr_idx] = wr_frame.dirty;
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // NOTE: tag/data storage is deliberately not reset; the valid bits gate every use of it.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_frame.tag;
      word_mem[wr_idx] <= wr_frame.word;
    end
  end
endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back data cache: serves dmemREN/dmemWEN, refills and flushes over dREN/dWEN.
module dcache_responder
  import cpu_types_pkg::*;
  import dcache_pkg::*;
#(
  parameter int SETS = 8,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  halt,
  input  logic  dmemREN,
  input  logic  dmemWEN,
  input  word_t dmemaddr,
  input  word_t dmemstore,
  output logic  dhit,
  output word_t dmemload,
  output logic  flushed,
  output logic  dREN,
  output logic  dWEN,
  output word_t daddr,
  output word_t dstore,
  input  word_t dload,
  input  logic  dwait
);
  localparam logic [IDX_W:0] LAST_IDX = (IDX_W + 1)'(SETS - 1);

  dcache_state_t    state_q, state_d;
  logic [IDX_W:0]   flush_idx_q, flush_idx_d;
  logic [IDX_W-1:0] req_idx, frame_idx;
  tag_t             req_tag;
  logic             blkoff;
  dcache_frame_t    rd_frame, wr_frame;
  logic             wr_en;

  assign req_idx = dmemaddr[IDX_LSB +: IDX_W];
  assign req_tag = addr_tag(dmemaddr, IDX_W);
  assign blkoff  = dmemaddr[BLK_OFF_BIT];
  // The flush walks its own index; everything else follows the held request.
  assign frame_idx = (state_q inside {FCHK, FWB0, FWB1}) ? flush_idx_q[IDX_W-1:0] : req_idx;

  dcache_frames #(.SETS(SETS)) u_frames (
    .CLK      (CLK),
    .nRST     (nRST),
    .rd_idx   (frame_idx),
    .rd_frame (rd_frame),
    .wr_en    (wr_en),
    .wr_idx   (frame_idx),
    .wr_frame (wr_frame)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    dhit        = 1'b0;
    dmemload    = '0;
    flushed     = 1'b0;
    dREN        = 1'b0;
    dWEN        = 1'b0;
    daddr       = '0;
    dstore      = '0;
    wr_en       = 1'b0;
    wr_frame    = rd_frame;

    case (state_q)
      IDLE: begin
        if (halt) begin
          state_d     = FCHK;
          flush_idx_d = '0;
        end else if (dmemREN || dmemWEN) begin
          if (rd_frame.valid && rd_frame.tag == req_tag) begin
            dhit = 1'b1;
            if (dmemWEN) begin
              wr_en                 = 1'b1;
              wr_frame.word[blkoff] = dmemstore;
              wr_frame.dirty        = 1'b1;
            end else begin
              dmemload = rd_frame.word[blkoff];
            end
          end else begin
            state_d = (rd_frame.valid && rd_frame.dirty) ? WB0 : LD0;
          end
        end
      end
      WB0, FWB0: begin
        dWEN   = 1'b1;
        daddr  = block_addr(rd_frame.tag, word_t'(frame_idx), IDX_W, 1'b0);
        dstore = rd_frame.word[0];
        if (!dwait) state_d = (state_q == WB0) ? WB1 : FWB1;
      end
      WB1, FWB1: begin
        dWEN   = 1'b1;
        daddr  = block_addr(rd_frame.tag, word_t'(frame_idx), IDX_W, 1'b1);
        dstore = rd_frame.word[1];
        if (!dwait) begin
          if (state_q == WB1) begin
            state_d = LD0;
          end else begin
            wr_en          = 1'b1;
            wr_frame.dirty = 1'b0;
            if (flush_idx_q == LAST_IDX) begin
              state_d = HALTED;
            end else begin
              flush_idx_d = flush_idx_q + (IDX_W + 1)'(1);
              state_d     = FCHK;
            end
          end
        end
      end
      LD0: begin
        dREN  = 1'b1;
        daddr = block_addr(req_tag, word_t'(frame_idx), IDX_W, 1'b0);
        if (!dwait) begin
          wr_en            = 1'b1;
          wr_frame.word[0] = dload;
          state_d          = LD1;
        end
      end
      LD1: begin
        dREN  = 1'b1;
        daddr = block_addr(req_tag, word_t'(frame_idx), IDX_W, 1'b1);
        if (!dwait) begin
          wr_en            = 1'b1;
          wr_frame.word[1] = dload;
          wr_frame.tag     = req_tag;
          wr_frame.valid   = 1'b1;
          wr_frame.dirty   = 1'b0;
          state_d          = IDLE;
        end
      end
      FCHK: begin
        if (rd_frame.valid && rd_frame.dirty) begin
          state_d = FWB0;
        end else if (flush_idx_q == LAST_IDX) begin
          state_d = HALTED;
        end else begin
          flush_idx_d = flush_idx_q + (IDX_W + 1)'(1);
        end
      end
      HALTED:  flushed = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q     <= IDLE;
      flush_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_idx_q <= flush_idx_d;
    end
  end
endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: vector table plus reset and flush sequences.
module tb_dcache_responder;
  logic        CLK = 1'b0;
  logic        nRST, halt, dmemREN, dmemWEN, dhit, flushed, dREN, dWEN, dwait;
  logic [31:0] dmemaddr, dmemstore, dmemload, daddr, dstore, dload;

  int n_cmp  = 0;
  int n_fail = 0;

  dcache_responder #(.SETS(8)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .halt      (halt),
    .dmemREN   (dmemREN),
    .dmemWEN   (dmemWEN),
    .dmemaddr  (dmemaddr),
    .dmemstore (dmemstore),
    .dhit      (dhit),
    .dmemload  (dmemload),
    .flushed   (flushed),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .dload     (dload),
    .dwait     (dwait)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ren, wen;
    logic [31:0] addr, store;
    logic        dwait;
    logic [31:0] dload;
    logic        dhit, chk_load;
    logic [31:0] load;
    logic        dren, dwen;
    logic [31:0] daddr, dstore;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t v(input logic ren, wen, input logic [31:0] addr, store,
                             input logic dw, input logic [31:0] dl,
                             input logic hit, chk, input logic [31:0] load,
                             input logic dren, dwen, input logic [31:0] da, ds);
    vec_t r;
    r.ren = ren; r.wen = wen; r.addr = addr; r.store = store; r.dwait = dw; r.dload = dl;
    r.dhit = hit; r.chk_load = chk; r.load = load;
    r.dren = dren; r.dwen = dwen; r.daddr = da; r.dstore = ds;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fill_write(input logic [31:0] addr, store, d0, d1);
    logic [31:0] base;
    base      = addr & ~32'h7;
    dmemREN   = 1'b0;
    dmemWEN   = 1'b1;
    dmemaddr  = addr;
    dmemstore = store;
    dwait     = 1'b0;
    @(negedge CLK); check("fill miss dhit", dhit, 0);
    tick();
    dload = d0;
    @(negedge CLK); check("fill LD0 daddr", daddr, base);
    tick();
    dload = d1;
    @(negedge CLK); check("fill LD1 daddr", daddr, base | 32'h4);
    tick();
    @(negedge CLK); check("fill write hit", dhit, 1);
    tick();
    dmemWEN = 1'b0;
  endtask

  logic [31:0] wb_addr [8];
  logic [31:0] wb_data [8];
  logic [31:0] exp_wb_addr [4];
  logic [31:0] exp_wb_data [4];
  int          n_wb;
  logic        done;

  initial begin
    //            ren wen addr        store         dw dload         hit chk load          dren dwen daddr      dstore
    vecs[0]  = v(1, 0, 32'h040, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,   32'h0);
    vecs[1]  = v(1, 0, 32'h040, 32'h0,        0, 32'h11111111, 0, 0, 32'h0,        1, 0, 32'h040, 32'h0);
    vecs[2]  = v(1, 0, 32'h040, 32'h0,        0, 32'h22222222, 0, 0, 32'h0,        1, 0, 32'h044, 32'h0);
    vecs[3]  = v(1, 0, 32'h040, 32'h0,        0, 32'h0,        1, 1, 32'h11111111, 0, 0, 32'h0,   32'h0);
    vecs[4]  = v(1, 0, 32'h044, 32'h0,        0, 32'h0,        1, 1, 32'h22222222, 0, 0, 32'h0,   32'h0);
    vecs[5]  = v(0, 1, 32'h040, 32'hDEADBEEF, 0, 32'h0,        1, 0, 32'h0,        0, 0, 32'h0,   32'h0);
    vecs[6]  = v(1, 0, 32'h040, 32'h0,        0, 32'h0,        1, 1, 32'hDEADBEEF, 0, 0, 32'h0,   32'h0);
    vecs[7]  = v(1, 0, 32'h140, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,   32'h0);
    vecs[8]  = v(1, 0, 32'h140, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 1, 32'h040, 32'hDEADBEEF);
    vecs[9]  = v(1, 0, 32'h140, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 1, 32'h044, 32'h22222222);
    vecs[10] = v(1, 0, 32'h140, 32'h0,        1, 32'h0,        0, 0, 32'h0,        1, 0, 32'h140, 32'h0);
    vecs[11] = v(1, 0, 32'h140, 32'h0,        1, 32'h0,        0, 0, 32'h0,        1, 0, 32'h140, 32'h0);
    vecs[12] = v(1, 0, 32'h140, 32'h0,        1, 32'h0,        0, 0, 32'h0,        1, 0, 32'h140, 32'h0);
    vecs[13] = v(1, 0, 32'h140, 32'h0,        0, 32'h33333333, 0, 0, 32'h0,        1, 0, 32'h140, 32'h0);
    vecs[14] = v(1, 0, 32'h140, 32'h0,        0, 32'h44444444, 0, 0, 32'h0,        1, 0, 32'h144, 32'h0);
    vecs[15] = v(1, 0, 32'h140, 32'h0,        0, 32'h0,        1, 1, 32'h33333333, 0, 0, 32'h0,   32'h0);
    vecs[16] = v(1, 0, 32'h144, 32'h0,        0, 32'h0,        1, 1, 32'h44444444, 0, 0, 32'h0,   32'h0);
    vecs[17] = v(1, 1, 32'h144, 32'h55555555, 0, 32'h0,        1, 0, 32'h0,        0, 0, 32'h0,   32'h0);
    vecs[18] = v(1, 0, 32'h144, 32'h0,        0, 32'h0,        1, 1, 32'h55555555, 0, 0, 32'h0,   32'h0);

    exp_wb_addr[0] = 32'h50; exp_wb_data[0] = 32'hA0A0A0A0;
    exp_wb_addr[1] = 32'h54; exp_wb_data[1] = 32'h54545454;
    exp_wb_addr[2] = 32'hA8; exp_wb_data[2] = 32'hA8A8A8A8;
    exp_wb_addr[3] = 32'hAC; exp_wb_data[3] = 32'hC0C0C0C0;

    nRST = 1'b1; halt = 1'b0; dmemREN = 1'b1; dmemWEN = 1'b0;
    dmemaddr = 32'h40; dmemstore = '0; dload = '0; dwait = 1'b0;
    repeat (2) tick();
    @(negedge CLK);
    check("reset dhit", dhit, 0);
    check("reset dmemload", dmemload, 0);
    check("reset flushed", flushed, 0);
    check("reset dREN", dREN, 0);
    check("reset dWEN", dWEN, 0);
    check("reset daddr", daddr, 0);
    check("reset dstore", dstore, 0);
    tick();
    nRST = 1'b0;

    foreach (vecs[i]) begin
      dmemREN = vecs[i].ren; dmemWEN = vecs[i].wen;
      dmemaddr = vecs[i].addr; dmemstore = vecs[i].store;
      dwait = vecs[i].dwait; dload = vecs[i].dload;
      @(negedge CLK);
      check($sformatf("v%0d dhit", i), dhit, vecs[i].dhit);
      check($sformatf("v%0d dREN", i), dREN, vecs[i].dren);
      check($sformatf("v%0d dWEN", i), dWEN, vecs[i].dwen);
      if (vecs[i].chk_load) check($sformatf("v%0d dmemload", i), dmemload, vecs[i].load);
      if (vecs[i].dren || vecs[i].dwen) check($sformatf("v%0d daddr", i), daddr, vecs[i].daddr);
      if (vecs[i].dwen) check($sformatf("v%0d dstore", i), dstore, vecs[i].dstore);
      tick();
    end

    // Reset while a refill is stalled in LD0.
    dmemREN = 1'b1; dmemWEN = 1'b0; dmemaddr = 32'h48; dwait = 1'b1;
    tick();
    @(negedge CLK);
    check("stall LD0 dREN", dREN, 1);
    check("stall LD0 daddr", daddr, 32'h48);
    nRST = 1'b1;
    tick();
    nRST = 1'b0;
    @(negedge CLK);
    check("post-reset dREN released", dREN, 0);
    check("post-reset dhit", dhit, 0);
    tick();
    @(negedge CLK);
    check("re-read misses dREN", dREN, 1);
    check("re-read misses daddr", daddr, 32'h48);
    nRST = 1'b1;
    tick();
    nRST = 1'b0;
    dmemaddr = 32'h144; dwait = 1'b0;
    @(negedge CLK);
    check("old line invalidated", dhit, 0);
    dmemREN = 1'b0;
    tick();

    // Dirty frames 2 and 5, then flush with intermittent dwait.
    fill_write(32'h50, 32'hA0A0A0A0, 32'h50505050, 32'h54545454);
    fill_write(32'hAC, 32'hC0C0C0C0, 32'hA8A8A8A8, 32'hACACACAC);
    halt = 1'b1; dmemREN = 1'b1; dmemaddr = 32'h50;
    n_wb = 0; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      dwait = (c % 3 == 1);
      @(negedge CLK);
      if (c == 0) check("halt beats hit", dhit, 0);
      if (dREN) check("flush dREN", dREN, 0);
      if (dWEN && !dwait) begin
        if (n_wb < 8) begin
          wb_addr[n_wb] = daddr;
          wb_data[n_wb] = dstore;
        end
        n_wb++;
      end
      if (flushed) done = 1'b1;
      tick();
    end
    check("flush completes", done, 1);
    check("flush transfer count", n_wb, 4);
    for (int i = 0; i < 4 && i < n_wb; i++) begin
      check($sformatf("flush wb%0d daddr", i), wb_addr[i], exp_wb_addr[i]);
      check($sformatf("flush wb%0d dstore", i), wb_data[i], exp_wb_data[i]);
    end

    halt = 1'b0; dwait = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      check($sformatf("halted c%0d flushed", c), flushed, 1);
      check($sformatf("halted c%0d quiet", c), {29'b0, dhit, dREN, dWEN}, 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Data-side responder on datapath_cache_if: answers the pipeline's dmemREN/dmemWEN requests with dhit/dmemload.
- Direct-mapped, write-back, write-allocate cache: 2-word blocks, SETS frames.
- On the memory side it masters a dREN/dWEN/daddr/dstore channel toward the memory controller and waits on dwait.
- On halt it writes back every dirty block, then asserts flushed.

Parameters:
SETS  8  number of frames; power of two, 2..64
IDX_W  $clog2(SETS)  index width (derived, not overridden)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset; synchronous, active-high (1 = reset), sampled on CLK rising edge
halt  in  1  pipeline halted; request full flush
dmemREN  in  1  load request
dmemWEN  in  1  store request
dmemaddr  in  32  word address, bits[1:0] ignored
dmemstore  in  32  store data
dhit  out  1  request satisfied this cycle
dmemload  out  32  load data, valid when dhit=1
flushed  out  1  flush complete, sticky until reset
dREN  out  1  memory read
dWEN  out  1  memory write
daddr  out  32  memory word address
dstore  out  32  memory write data
dload  in  32  memory read data, valid when dwait=0 and dREN=1
dwait  in  1  memory busy; transfer completes on a cycle with dwait=0

Behaviour:
- Address split: tag = [31:3+IDX_W], index = [2+IDX_W:3], blkoff = [2], byte = [1:0].
- Frame state: valid, dirty, tag, word[0..1].
- Reset (nRST=1 at edge): all valid/dirty=0, state=IDLE, flush index=0. Outputs dhit=0, dmemload=0, flushed=0, dREN=dWEN=0, daddr=0, dstore=0.
- IDLE:
  - hit = valid & tag match & (dmemREN|dmemWEN); dhit asserted combinationally, same cycle, zero latency.
  - Read hit: dmemload = word[blkoff].
  - Write hit: word[blkoff]<=dmemstore and dirty<=1 at the edge.
  - dmemREN & dmemWEN together: treated as a write.
  - Miss: go to WB0 if victim valid&dirty, else LD0. dhit=0 throughout the miss.
- WB0: dWEN=1, daddr={victim tag,index,0,00}, dstore=word[0]; advance to WB1 on dwait=0.
- WB1: same with blkoff=1, word[1]; on dwait=0 go to LD0.
- LD0: dREN=1, daddr={req tag,index,0,00}; on dwait=0 capture dload into word[0], go to LD1.
- LD1: blkoff=1, capture into word[1]. On dwait=0: set tag, valid=1, dirty=0, go to IDLE.
- After a miss: the request, still held by the pipeline, hits in IDLE the next cycle. Total miss latency = 1 + memory cycles + 1.
- Only dwait gates memory-side transitions. dREN/dWEN/daddr/dstore are held stable while dwait=1.
- halt sampled only in IDLE. If halt=1 in IDLE it takes priority over any request (dhit=0) and enters FCHK with flush index=0.
- FCHK:
  - frame[idx] valid&dirty: go to FWB0.
  - else if idx==SETS-1: go to HALTED.
  - else idx++.
- FWB0/FWB1: write back word0/word1 as WB0/WB1. After FWB1 completes, clear dirty[idx], then wrap-check as in FCHK.
- HALTED: flushed=1; all memory outputs 0; dhit=0; requests ignored. Only reset exits.
- A miss in progress when halt rises completes its refill first; halt is then seen in IDLE.
- Reset mid-transaction: state, valid/dirty and outputs cleared at that edge; the bus is released the following cycle.
- Index counter is IDX_W+1 bits wide, so index SETS-1 is reachable without wrap ambiguity.

Decomposition:
- Package dcache_pkg: dcache_state_t enum (IDLE, WB0, WB1, LD0, LD1, FCHK, FWB0, FWB1, HALTED); dcache_frame_t struct {valid, dirty, tag, word[2]}; address-split helper constants.
- Shared types stay in the existing CPU types package (word_t).
- One natural sub-module: dcache_frames, the frame array with combinational read port and single registered write port. The FSM stays in dcache_responder.

Test Plan:
- Cold read 0x00000040, dwait=0 → LD0 daddr=0x40, LD1 daddr=0x44. dload 0x11111111/0x22222222. dhit=1 with dmemload=0x11111111 on cycle 3.
- Read hit 0x44 after the fill → dhit=1 same cycle, dmemload=0x22222222, dREN stays 0.
- Write 0x40 ← 0xDEADBEEF (hit), then read 0x00000140 (same index 0, new tag) → WB0 daddr=0x40 dstore=0xDEADBEEF, WB1 daddr=0x44 dstore=0x22222222, then LD0 daddr=0x140.
- dwait held 1 for 3 cycles in LD0 → daddr=0x140 and dREN stable all 3 cycles, no state advance, dhit=0.
- Frames 2 and 5 dirty, then halt=1 → exactly 4 dWEN transfers at 0x50, 0x54, 0xA8, 0xAC in order. flushed=1 afterwards, sticky across 10 cycles.
- nRST=1 during LD0 with dwait=1 → next cycle dREN=0, state IDLE. Re-read of the same address misses again.
